// File: rtl/multiplier_pkg.sv
// Shared definitions for the iterative shift-add multiplier.
//   state_t        : control FSM states (IDLE, CALC, DONE)
//   DEFAULT_WIDTH  : default operand width in bits
package multiplier_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/mult_step.sv
// One radix-2 shift-add step of an unsigned multiplier (purely combinational).
//   acc      : current 2*WIDTH accumulator {upper half, lower half}
//   mcand    : multiplicand magnitude
//   mplr_bit : current multiplier LSB, selects whether mcand is added
//   acc_next : accumulator after the conditional add and the right shift
module mult_step
    import multiplier_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [2*WIDTH-1:0] acc,
    input  logic [WIDTH-1:0]   mcand,
    input  logic               mplr_bit,
    output logic [2*WIDTH-1:0] acc_next
);

    logic [WIDTH-1:0] addend_s;
    logic [WIDTH:0]   sum_s;
    logic [2*WIDTH:0] wide_s;

    // Conditional add into the upper half; the sum keeps its carry bit,
    // which becomes the new MSB after the shift.
    always_comb begin
        if (mplr_bit) begin
            addend_s = mcand;
        end else begin
            addend_s = '0;
        end
        sum_s    = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, addend_s};
        wide_s   = {sum_s, acc[WIDTH-1:0]};
        acc_next = (2*WIDTH)'(wide_s >> 1);
    end

endmodule

// File: rtl/iter_multiplier.sv
// Iterative signed/unsigned multiplier with valid/ready handshakes.
// Magnitudes are multiplied with WIDTH shift-add steps and the sign is
// applied on the final step, so latency is fixed regardless of operands.
//   clk, reset          : clock and synchronous active-high reset
//   A, B, signed_mode   : operands and two's-complement select
//   in_valid / in_ready : operand handshake (ready only in IDLE)
//   result              : 2*WIDTH product, held until the next completion
//   out_valid/out_ready : result handshake (valid only in DONE)
module iter_multiplier
    import multiplier_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    input  logic               signed_mode,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [2*WIDTH-1:0] result,
    output logic               out_valid,
    input  logic               out_ready
);

    localparam int PW = 2 * WIDTH;
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    state_t          state_r;
    state_t          state_s;
    logic [WIDTH-1:0] mcand_r;
    logic [WIDTH-1:0] mplr_r;
    logic [WIDTH-1:0] a_mag_s;
    logic [WIDTH-1:0] b_mag_s;
    logic [PW-1:0]    acc_r;
    logic [PW-1:0]    acc_next_s;
    logic [PW-1:0]    product_s;
    logic [PW-1:0]    result_r;
    logic [CW-1:0]    cnt_r;
    logic             neg_r;
    logic             out_valid_r;
    logic             accept_s;
    logic             last_step_s;

    // Single shift-add step applied every CALC cycle.
    mult_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .acc      (acc_r),
        .mcand    (mcand_r),
        .mplr_bit (mplr_r[0]),
        .acc_next (acc_next_s)
    );

    // Operand magnitudes; the most negative value maps onto itself, which
    // is the correct unsigned magnitude 2^(WIDTH-1).
    always_comb begin
        if (signed_mode && A[WIDTH-1]) begin
            a_mag_s = ~A + WIDTH'(1);
        end else begin
            a_mag_s = A;
        end
        if (signed_mode && B[WIDTH-1]) begin
            b_mag_s = ~B + WIDTH'(1);
        end else begin
            b_mag_s = B;
        end
    end

    // Final product: the last step's accumulator, negated when the signs differed.
    always_comb begin
        if (neg_r) begin
            product_s = ~acc_next_s + PW'(1);
        end else begin
            product_s = acc_next_s;
        end
    end

    // Next-state and handshake decode.
    always_comb begin
        state_s     = state_r;
        accept_s    = 1'b0;
        last_step_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (in_valid && !reset) begin
                    accept_s = 1'b1;
                    state_s  = CALC;
                end else begin
                    state_s  = IDLE;
                end
            end
            CALC: begin
                if (cnt_r == CNT_LAST) begin
                    last_step_s = 1'b1;
                    state_s     = DONE;
                end else begin
                    state_s     = CALC;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_s = IDLE;
                end else begin
                    state_s = DONE;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Datapath: operand capture, shift-add iteration and result hold.
    always_ff @(posedge clk) begin
        if (reset) begin
            mcand_r     <= '0;
            mplr_r      <= '0;
            acc_r       <= '0;
            cnt_r       <= '0;
            neg_r       <= 1'b0;
            result_r    <= '0;
            out_valid_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        mcand_r <= a_mag_s;
                        mplr_r  <= b_mag_s;
                        neg_r   <= signed_mode & (A[WIDTH-1] ^ B[WIDTH-1]);
                        acc_r   <= '0;
                        cnt_r   <= '0;
                    end
                end
                CALC: begin
                    acc_r  <= acc_next_s;
                    mplr_r <= mplr_r >> 1;
                    cnt_r  <= cnt_r + CW'(1);
                    if (last_step_s) begin
                        result_r    <= product_s;
                        out_valid_r <= 1'b1;
                    end
                end
                DONE: begin
                    // result_r is left untouched so the product survives consumption.
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                    end
                end
                default: begin
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

    // Ready only while idle and not being held in reset.
    assign in_ready  = (state_r == IDLE) && !reset;
    assign result    = result_r;
    assign out_valid = out_valid_r;

endmodule

// File: tb/tb_iter_multiplier.sv
// Scoreboard bench for iter_multiplier (WIDTH=8). The driver pushes the
// reference product and accept time per operand pair; a monitor pops and
// compares result and latency whenever out_valid rises. The accept edge is
// counted as the first of the WIDTH+1 edges, so out_valid rises on the edge
// WIDTH clock periods after the accept edge.
module tb_iter_multiplier;

    localparam int W  = 8;
    localparam int PW = 2 * W;

    typedef struct {
        logic [PW-1:0] res;
        time           t;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [W-1:0]  a_in = '0;
    logic [W-1:0]  b_in = '0;
    logic          signed_mode = 1'b0;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b1;
    logic          in_ready;
    logic [PW-1:0] result;
    logic          out_valid;

    int   errors = 0;
    int   checks = 0;
    bit   rand_bp = 1'b0;
    exp_t q[$];
    exp_t mon_e;
    logic prev_ov = 1'b0;

    iter_multiplier #(.WIDTH(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .A           (a_in),
        .B           (b_in),
        .signed_mode (signed_mode),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .result      (result),
        .out_valid   (out_valid),
        .out_ready   (out_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: plain integer multiply of the operands as numbers.
    function automatic logic [PW-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b, input logic sm);
        longint p;
        logic signed [W-1:0] sa;
        logic signed [W-1:0] sb;
        sa = a;
        sb = b;
        if (sm) p = longint'(sa) * longint'(sb);
        else    p = longint'(a) * longint'(b);
        return p[PW-1:0];
    endfunction

    // Monitor: on every rising out_valid compare against the oldest expectation.
    always @(negedge clk) begin
        if (out_valid && !prev_ov) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out_valid: got result 0x%0h with no pending operation", result);
            end else begin
                mon_e = q.pop_front();
                check("result", result, mon_e.res);
                check("latency_edges", ($time - 64'd5 - mon_e.t) / 64'd10, W);
            end
        end
        prev_ov = out_valid;
    end

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic sm,
                         input bit push, input bit hold, output time t_acc);
        exp_t e;
        int   n;
        n = 0;
        t_acc = 0;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            if (rand_bp) out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL in_ready_timeout: got in_ready=0 expected 1 within 200 cycles");
            return;
        end
        a_in = a;
        b_in = b;
        signed_mode = sm;
        in_valid = 1'b1;
        @(posedge clk);
        t_acc = $time;
        if (push) begin
            e.res = ref_mul(a, b, sm);
            e.t   = $time;
            q.push_back(e);
        end
        if (!hold) begin
            #1;
            in_valid = 1'b0;
            // Scramble operands after accept; the product in flight must not change.
            a_in = W'($urandom);
            b_in = W'($urandom);
            signed_mode = 1'($urandom);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q.size() != 0 || out_valid) && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d pending results expected 0", q.size());
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        time t1;
        time t2;
        int  n;
        logic [W-1:0] corners [5];
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        corners = '{'0, W'(1), {1'b0, {(W-1){1'b1}}}, {1'b1, {(W-1){1'b0}}}, '1};

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_in_ready", in_ready, 1'b0);
        check("reset_out_valid", out_valid, 1'b0);
        check("reset_result", result, '0);
        reset = 1'b0;
        @(negedge clk);
        check("in_ready_after_reset", in_ready, 1'b1);

        // Unsigned maximum, signed corner cases
        out_ready = 1'b1;
        issue(8'hFF, 8'hFF, 1'b0, 1'b1, 1'b0, t1);
        drain();
        issue(8'h80, 8'h80, 1'b1, 1'b1, 1'b0, t1);
        issue(8'h80, 8'h01, 1'b1, 1'b1, 1'b0, t1);
        issue(8'hFD, 8'h07, 1'b1, 1'b1, 1'b0, t1);
        drain();

        // Zero product under back-pressure
        out_ready = 1'b0;
        issue(8'h00, 8'h5A, 1'b0, 1'b1, 1'b0, t1);
        n = 0;
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        repeat (20) begin
            @(negedge clk);
            check("bp_out_valid", out_valid, 1'b1);
            check("bp_result", result, '0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("consume_out_valid", out_valid, 1'b0);
        check("consume_in_ready", in_ready, 1'b1);
        check("result_kept", result, '0);

        // Back-to-back with in_valid held high
        issue(8'd3, 8'd4, 1'b0, 1'b1, 1'b1, t1);
        issue(8'd12, 8'd13, 1'b0, 1'b1, 1'b0, t2);
        check("b2b_accept_gap", (t2 - t1) / 64'd10, W + 2);
        drain();

        // Reset mid-CALC: pair is discarded, no expectation pushed
        issue(8'd200, 8'd200, 1'b0, 1'b0, 1'b0, t1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("abort_out_valid", out_valid, 1'b0);
        check("abort_result", result, '0);
        reset = 1'b0;
        @(negedge clk);
        check("abort_in_ready", in_ready, 1'b1);
        repeat (12) @(negedge clk);
        issue(8'd2, 8'd3, 1'b0, 1'b1, 1'b0, t1);
        drain();

        // Randomized operands with random back-pressure
        rand_bp = 1'b1;
        for (int i = 0; i < 60; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            if ($urandom_range(0, 3) == 0) ra = corners[$urandom_range(0, 4)];
            if ($urandom_range(0, 3) == 0) rb = corners[$urandom_range(0, 4)];
            issue(ra, rb, 1'($urandom), 1'b1, 1'b0, t1);
        end
        rand_bp = 1'b0;
        out_ready = 1'b1;
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
